// File: rtl/motion_pkg.sv
// Shared types and default tuning for the motion alarm controller.
package motion_pkg;

  localparam int unsigned SAMPLE_W = 7;
  localparam int unsigned ZONES    = 3;
  localparam int unsigned CONF_W   = 4;
  localparam int unsigned DLY_W    = 8;
  localparam int unsigned BUZZ_W   = 8;
  localparam int unsigned EVT_W    = 8;

  localparam int unsigned THRESH_DEF         = 20;
  localparam int unsigned CONFIRM_CYCLES_DEF = 3;
  localparam int unsigned ARM_DELAY_DEF      = 4;
  localparam int unsigned BUZZ_HALF_DEF      = 2;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_ALARM    = 2'd3
  } state_e;

endpackage

// File: rtl/pir_confirm.sv
// One PIR zone: threshold compare plus saturating run-length counter.
// o_trip_c pulses on the sample that completes the qualifying run.
module pir_confirm
  import motion_pkg::*;
#(
  parameter int unsigned THRESH         = THRESH_DEF,
  parameter int unsigned CONFIRM_CYCLES = CONFIRM_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_clear,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_trip_c
);

  logic [CONF_W-1:0] r_cnt;
  logic              w_above;
  logic              w_sat;

  // Equal to threshold is not motion.
  assign w_above  = i_sample > SAMPLE_W'(THRESH);
  assign w_sat    = r_cnt == CONF_W'(CONFIRM_CYCLES);
  assign o_trip_c = i_en && !i_clear && w_above &&
                    (r_cnt == CONF_W'(CONFIRM_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || !i_en || !w_above) begin
      r_cnt <= '0;
    end else if (!w_sat) begin
      r_cnt <= r_cnt + CONF_W'(1);
    end
  end

endmodule

// File: rtl/motion_alarm_ctrl.sv
// Three-zone PIR intrusion alarm: exit delay, confirmed trips, buzzer and
// entry counting.
module motion_alarm_ctrl
  import motion_pkg::*;
#(
  parameter int unsigned THRESH         = THRESH_DEF,
  parameter int unsigned CONFIRM_CYCLES = CONFIRM_CYCLES_DEF,
  parameter int unsigned ARM_DELAY      = ARM_DELAY_DEF,
  parameter int unsigned BUZZ_HALF      = BUZZ_HALF_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                turn,
  input  logic                stop_alarm,
  input  logic [SAMPLE_W-1:0] pir_sensor_1,
  input  logic [SAMPLE_W-1:0] pir_sensor_2,
  input  logic [SAMPLE_W-1:0] pir_sensor_3,
  output logic                alarm,
  output logic                buzzer,
  output logic                armed,
  output logic [ZONES-1:0]    zone,
  output logic [EVT_W-1:0]    event_count
);

  state_e              r_state, w_state_nxt;
  logic [DLY_W-1:0]    r_dly, w_dly_nxt;
  logic [BUZZ_W-1:0]   r_bcnt, w_bcnt_nxt;
  logic                r_buzz, w_buzz_nxt;
  logic                r_alarm, r_armed;
  logic [ZONES-1:0]    r_zone, w_zone_nxt;
  logic [EVT_W-1:0]    r_evt, w_evt_nxt;
  logic [ZONES-1:0]    w_trip;
  logic                w_sense_en;
  logic                w_sense_clr;

  // Sensors only count while armed; a disarm or an acknowledge restarts them.
  assign w_sense_en  = (r_state == ST_ARMED) || (r_state == ST_ALARM);
  assign w_sense_clr = !turn || ((r_state == ST_ALARM) && stop_alarm);

  pir_confirm #(.THRESH(THRESH), .CONFIRM_CYCLES(CONFIRM_CYCLES)) u_pir_1 (
    .clk(clk), .rst(rst), .i_en(w_sense_en), .i_clear(w_sense_clr),
    .i_sample(pir_sensor_1), .o_trip_c(w_trip[0])
  );
  pir_confirm #(.THRESH(THRESH), .CONFIRM_CYCLES(CONFIRM_CYCLES)) u_pir_2 (
    .clk(clk), .rst(rst), .i_en(w_sense_en), .i_clear(w_sense_clr),
    .i_sample(pir_sensor_2), .o_trip_c(w_trip[1])
  );
  pir_confirm #(.THRESH(THRESH), .CONFIRM_CYCLES(CONFIRM_CYCLES)) u_pir_3 (
    .clk(clk), .rst(rst), .i_en(w_sense_en), .i_clear(w_sense_clr),
    .i_sample(pir_sensor_3), .o_trip_c(w_trip[2])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_DISARMED;
      r_dly   <= '0;
      r_bcnt  <= '0;
      r_buzz  <= 1'b0;
      r_alarm <= 1'b0;
      r_armed <= 1'b0;
      r_zone  <= '0;
      r_evt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_buzz  <= w_buzz_nxt;
      r_alarm <= (w_state_nxt == ST_ALARM);
      r_armed <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_ALARM);
      r_zone  <= w_zone_nxt;
      r_evt   <= w_evt_nxt;
    end
  end

  // Next state and next registered outputs; disarm outranks everything.
  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_bcnt_nxt  = '0;
    w_buzz_nxt  = 1'b0;
    w_zone_nxt  = r_zone;
    w_evt_nxt   = r_evt;
    case (r_state)
      ST_DISARMED: begin
        if (turn) begin
          w_state_nxt = ST_ARMING;
          w_dly_nxt   = '0;
        end
      end
      ST_ARMING: begin
        if (!turn) begin
          w_state_nxt = ST_DISARMED;
        end else if (r_dly == DLY_W'(ARM_DELAY - 1)) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_dly_nxt = r_dly + DLY_W'(1);
        end
      end
      ST_ARMED: begin
        if (!turn) begin
          w_state_nxt = ST_DISARMED;
          w_zone_nxt  = '0;
        end else if (|w_trip) begin
          w_state_nxt = ST_ALARM;
          w_zone_nxt  = w_trip;
          w_buzz_nxt  = 1'b1;
          if (r_evt != {EVT_W{1'b1}}) begin
            w_evt_nxt = r_evt + EVT_W'(1);
          end
        end
      end
      ST_ALARM: begin
        if (!turn) begin
          w_state_nxt = ST_DISARMED;
          w_zone_nxt  = '0;
        end else if (stop_alarm) begin
          w_state_nxt = ST_ARMED;
          w_zone_nxt  = '0;
        end else begin
          w_zone_nxt = r_zone | w_trip;
          if (r_bcnt == BUZZ_W'(BUZZ_HALF - 1)) begin
            w_buzz_nxt = !r_buzz;
          end else begin
            w_buzz_nxt = r_buzz;
            w_bcnt_nxt = r_bcnt + BUZZ_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_DISARMED;
    endcase
  end

  assign alarm       = r_alarm;
  assign buzzer      = r_buzz;
  assign armed       = r_armed;
  assign zone        = r_zone;
  assign event_count = r_evt;

endmodule
